rv32_exec_mem_stage: RTL and testbench
======================================

# rv32_exec_mem_stage

Combinational RV32I instruction decoder, 32-bit ALU and word-organised data memory in one block, forming the decode/execute/memory slice of the single-cycle softcore. It receives the fetched instruction and the two register-file read values. It produces the decoded fields, the ALU result and the load data returned to the register-file write port. The data memory is the only state in the block.

## Interface
Parameters:
- MEM_WORDS, 64, data memory depth in 32-bit words; must be a power of two ≥ 2.

Ports:
- clk_i  in  1  clock; all memory writes occur on its rising edge.
- reset_i  in  1  reset; asynchronous, active-high; one clock domain.
- instruction_i  in  32  instruction word to decode.
- reg_data_1_i  in  32  rs1 value from the register file.
- reg_data_2_i  in  32  rs2 value from the register file; also the store data.
- alu_control_i  in  3  ALU operation select.
- alu_src_i  in  1  ALU operand-2 select: 0 = reg_data_2_i, 1 = immediate.
- mem_write_i  in  1  data memory write enable.
- opcode_o  out  7  instruction[6:0].
- rd_o  out  5  instruction[11:7].
- funct3_o  out  3  instruction[14:12].
- rs1_o  out  5  instruction[19:15].
- rs2_o  out  5  instruction[24:20].
- funct7_o  out  7  instruction[31:25].
- immediate_i_o, immediate_s_o, immediate_u_o, immediate_b_o, immediate_j_o  out  32 each  decoded immediates.
- alu_result_o  out  32  ALU result; also the data memory byte address.
- zero_o  out  1  1 when alu_result_o == 0.
- mem_data_o  out  32  data memory read data.

## Operation
Decoder (purely combinational):
- I = sext(instr[31:20]).
- S = sext({instr[31:25], instr[11:7]}).
- U = {instr[31:12], 12'b0}.
- B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
- J = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).

ALU operands:
- A = reg_data_1_i.
- B = reg_data_2_i when alu_src_i = 0.
- When alu_src_i = 1, B = immediate_s if opcode == 7'b0100011 (store), otherwise immediate_i.

ALU operations:
- 000 AND.
- 001 OR.
- 010 ADD.
- 011 XOR.
- 100 SLL by B[4:0].
- 101 SRL (logical) by B[4:0].
- 110 SUB (A−B).
- 111 SLT, signed; result is 32'd1 or 32'd0.
- Add and subtract wrap modulo 2^32; there is no overflow flag.

Data memory:
- Array of MEM_WORDS × 32-bit words, indexed by alu_result_o[log2(MEM_WORDS)+1:2].
- Address bits [1:0] are ignored (word-aligned access only).
- Address bits above the index are ignored, so addresses wrap modulo MEM_WORDS×4.
- Read is combinational: mem_data_o = mem[index].
- Write: on the rising clk_i edge with mem_write_i = 1 and reset_i = 0, mem[index] ← reg_data_2_i.
- Reset: while reset_i = 1, every word reads 0 and writes are ignored. Deassertion needs no synchronisation inside the block.

## Timing
- Decoder, ALU, zero_o and mem_data_o settle combinationally in the same cycle as their inputs; zero latency.
- A write becomes visible on mem_data_o immediately after the clock edge that performs it.
- Read during write to the same word: mem_data_o shows the old value before the edge and the new value after it.
- Reset asserted mid-cycle clears the memory immediately, without waiting for a clock edge. mem_data_o then reads 0, and decoder/ALU outputs are unaffected.
- When reset coincides with a write edge, reset wins and the word reads 0.

## Test plan
- Decode: instruction_i = 32'hFFF00093 (addi x1,x0,-1) → opcode 0010011, rd 1, rs1 0, funct3 0, immediate_i_o = 32'hFFFFFFFF.
- Immediates: instruction_i = 32'hFE112E23 (sw x1,-4(x2)) → immediate_s_o = 32'hFFFFFFFC. 32'h123450B7 → immediate_u_o = 32'h12345000. B and J immediates are checked against a reference model for 32'h8000_0063 and 32'h8000_006F.
- ALU sweep, with A = 32'h8000_0001, B = 32'h0000_0003, alu_src_i = 0:
  - ADD → 32'h80000004.
  - SUB → 32'h7FFFFFFE.
  - SLL → 32'h00000008.
  - SRL → 32'h10000000.
  - SLT → 1.
  - AND → 1.
  - OR → 32'h80000003.
  - XOR → 32'h80000002.
  - A = B gives SUB = 0 with zero_o = 1.
- Store/load: A = 32'h10, S-immediate 4, alu_src_i = 1, mem_write_i = 1, reg_data_2_i = 32'hDEADBEEF for one edge. After the edge, a load (opcode 0000011, I-immediate 4) returns mem_data_o = 32'hDEADBEEF; the address wraps, so 32'h14 + 4×MEM_WORDS returns the same value.
- Reset: after writes, assert reset_i asynchronously between edges → mem_data_o = 0 immediately. A write attempted while reset_i = 1 has no effect after deassertion.
- Read-during-write: hold the address and change the write data → the old value appears before the edge and the new value after it.

Source files
------------

// File: rtl/rv32_exec_mem_stage.sv
// Decode/execute/memory slice of the single-cycle RV32I softcore.
// Decodes the instruction fields and immediates, runs the 32-bit ALU and
// provides a word-organised data memory addressed by the ALU result.
// Ports:
//   clk_i, reset_i           clock, async active-high reset (clears memory)
//   instruction_i            instruction word to decode
//   reg_data_1_i/2_i         rs1/rs2 register values (rs2 is also store data)
//   alu_control_i, alu_src_i ALU operation and operand-2 select
//   mem_write_i              data memory write enable
//   opcode_o..funct7_o       decoded instruction fields
//   immediate_*_o            decoded I/S/U/B/J immediates
//   alu_result_o, zero_o     ALU result (also byte address) and zero flag
//   mem_data_o               combinational memory read data
module rv32_exec_mem_stage #(
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] instruction_i,
  input  logic [31:0] reg_data_1_i,
  input  logic [31:0] reg_data_2_i,
  input  logic [2:0]  alu_control_i,
  input  logic        alu_src_i,
  input  logic        mem_write_i,
  output logic [6:0]  opcode_o,
  output logic [4:0]  rd_o,
  output logic [2:0]  funct3_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [6:0]  funct7_o,
  output logic [31:0] immediate_i_o,
  output logic [31:0] immediate_s_o,
  output logic [31:0] immediate_u_o,
  output logic [31:0] immediate_b_o,
  output logic [31:0] immediate_j_o,
  output logic [31:0] alu_result_o,
  output logic        zero_o,
  output logic [31:0] mem_data_o
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam logic [6:0]  OPC_STORE = 7'b0100011;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Field and immediate decode
  assign opcode_o = instruction_i[6:0];
  assign rd_o     = instruction_i[11:7];
  assign funct3_o = instruction_i[14:12];
  assign rs1_o    = instruction_i[19:15];
  assign rs2_o    = instruction_i[24:20];
  assign funct7_o = instruction_i[31:25];

  assign immediate_i_o = {{20{instruction_i[31]}}, instruction_i[31:20]};
  assign immediate_s_o = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
  assign immediate_u_o = {instruction_i[31:12], 12'b0};
  assign immediate_b_o = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                          instruction_i[30:25], instruction_i[11:8], 1'b0};
  assign immediate_j_o = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                          instruction_i[20], instruction_i[30:21], 1'b0};

  // Operand-2 select: stores take the S immediate, everything else the I immediate
  logic [31:0] op_a;
  logic [31:0] op_b;

  assign op_a = reg_data_1_i;

  always_comb begin
    op_b = reg_data_2_i;
    if (alu_src_i) begin
      op_b = (opcode_o == OPC_STORE) ? immediate_s_o : immediate_i_o;
    end
  end

  // ALU
  always_comb begin
    alu_result_o = 32'd0;
    unique case (alu_control_i)
      ALU_AND: alu_result_o = op_a & op_b;
      ALU_OR:  alu_result_o = op_a | op_b;
      ALU_ADD: alu_result_o = op_a + op_b;
      ALU_XOR: alu_result_o = op_a ^ op_b;
      ALU_SLL: alu_result_o = op_a << op_b[4:0];
      ALU_SRL: alu_result_o = op_a >> op_b[4:0];
      ALU_SUB: alu_result_o = op_a - op_b;
      ALU_SLT: alu_result_o = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
      default: alu_result_o = 32'd0;
    endcase
  end

  assign zero_o = (alu_result_o == 32'd0);

  // Data memory: byte address bits [1:0] and bits above the index are dropped
  logic [31:0]      mem [MEM_WORDS];
  logic [IDX_W-1:0] mem_idx;

  assign mem_idx = alu_result_o[IDX_W+1:2];

  // Reset clears the whole array asynchronously and blocks writes while held
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) begin
        mem[i] <= 32'd0;
      end
    end else if (mem_write_i) begin
      mem[mem_idx] <= reg_data_2_i;
    end
  end

  assign mem_data_o = mem[mem_idx];

endmodule

// File: tb/tb_rv32_exec_mem_stage.sv
// Directed self-checking bench for rv32_exec_mem_stage.
module tb_rv32_exec_mem_stage;

  localparam int unsigned MEM_WORDS = 64;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] instruction_i;
  logic [31:0] reg_data_1_i;
  logic [31:0] reg_data_2_i;
  logic [2:0]  alu_control_i;
  logic        alu_src_i;
  logic        mem_write_i;
  logic [6:0]  opcode_o;
  logic [4:0]  rd_o;
  logic [2:0]  funct3_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [6:0]  funct7_o;
  logic [31:0] immediate_i_o, immediate_s_o, immediate_u_o, immediate_b_o, immediate_j_o;
  logic [31:0] alu_result_o;
  logic        zero_o;
  logic [31:0] mem_data_o;

  int errors = 0;
  int checks = 0;

  rv32_exec_mem_stage #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .instruction_i(instruction_i),
    .reg_data_1_i(reg_data_1_i), .reg_data_2_i(reg_data_2_i),
    .alu_control_i(alu_control_i), .alu_src_i(alu_src_i), .mem_write_i(mem_write_i),
    .opcode_o(opcode_o), .rd_o(rd_o), .funct3_o(funct3_o), .rs1_o(rs1_o),
    .rs2_o(rs2_o), .funct7_o(funct7_o),
    .immediate_i_o(immediate_i_o), .immediate_s_o(immediate_s_o),
    .immediate_u_o(immediate_u_o), .immediate_b_o(immediate_b_o),
    .immediate_j_o(immediate_j_o),
    .alu_result_o(alu_result_o), .zero_o(zero_o), .mem_data_o(mem_data_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [31:0] INSTR_SW = 32'h0000_2223;  // sw, S-imm 4, I-imm 0
  localparam logic [31:0] INSTR_LW = 32'h0040_2003;  // lw, I-imm 4, S-imm 0

  task automatic test_reset();
    reset_i = 1'b1; mem_write_i = 1'b0; alu_src_i = 1'b0; alu_control_i = 3'b010;
    instruction_i = 32'h0; reg_data_1_i = 32'h14; reg_data_2_i = 32'h0;
    #2;
    checks++; if (mem_data_o !== 32'h0) begin errors++; $display("FAIL reset_mem: got %h want %h", mem_data_o, 32'h0); end
    checks++; if (alu_result_o !== 32'h14) begin errors++; $display("FAIL reset_alu: got %h want %h", alu_result_o, 32'h14); end
    @(negedge clk_i); reset_i = 1'b0; #1;
    checks++; if (mem_data_o !== 32'h0) begin errors++; $display("FAIL post_reset_mem: got %h want %h", mem_data_o, 32'h0); end
  endtask

  task automatic test_decode();
    instruction_i = 32'hFFF0_0093; #1;
    checks++; if (opcode_o !== 7'b0010011) begin errors++; $display("FAIL dec_opcode: got %b want %b", opcode_o, 7'b0010011); end
    checks++; if (rd_o !== 5'd1) begin errors++; $display("FAIL dec_rd: got %0d want 1", rd_o); end
    checks++; if (rs1_o !== 5'd0) begin errors++; $display("FAIL dec_rs1: got %0d want 0", rs1_o); end
    checks++; if (funct3_o !== 3'd0) begin errors++; $display("FAIL dec_funct3: got %0d want 0", funct3_o); end
    checks++; if (rs2_o !== 5'h1F) begin errors++; $display("FAIL dec_rs2: got %h want 1f", rs2_o); end
    checks++; if (funct7_o !== 7'h7F) begin errors++; $display("FAIL dec_funct7: got %h want 7f", funct7_o); end
    checks++; if (immediate_i_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dec_imm_i: got %h want ffffffff", immediate_i_o); end
  endtask

  task automatic test_immediates();
    instruction_i = 32'hFE11_2E23; #1;
    checks++; if (immediate_s_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL imm_s: got %h want fffffffc", immediate_s_o); end
    instruction_i = 32'h1234_50B7; #1;
    checks++; if (immediate_u_o !== 32'h1234_5000) begin errors++; $display("FAIL imm_u: got %h want 12345000", immediate_u_o); end
    instruction_i = 32'h8000_0063; #1;
    checks++; if (immediate_b_o !== 32'hFFFF_F000) begin errors++; $display("FAIL imm_b: got %h want fffff000", immediate_b_o); end
    instruction_i = 32'h8000_006F; #1;
    checks++; if (immediate_j_o !== 32'hFFF0_0000) begin errors++; $display("FAIL imm_j: got %h want fff00000", immediate_j_o); end
    // beq with offset +0x800 | 0x7FE pattern: imm bits 11..1 all set, sign clear
    instruction_i = 32'h7E00_0FE3; #1;
    checks++; if (immediate_b_o !== 32'h0000_0FFE) begin errors++; $display("FAIL imm_b_pos: got %h want 00000ffe", immediate_b_o); end
  endtask

  task automatic test_alu();
    logic [2:0]  ops  [8] = '{3'b010, 3'b110, 3'b100, 3'b101, 3'b111, 3'b000, 3'b001, 3'b011};
    logic [31:0] exps [8] = '{32'h8000_0004, 32'h7FFF_FFFE, 32'h0000_0008, 32'h1000_0000,
                              32'h0000_0001, 32'h0000_0001, 32'h8000_0003, 32'h8000_0002};
    instruction_i = 32'h0; alu_src_i = 1'b0;
    reg_data_1_i = 32'h8000_0001; reg_data_2_i = 32'h0000_0003;
    for (int i = 0; i < 8; i++) begin
      alu_control_i = ops[i]; #1;
      checks++; if (alu_result_o !== exps[i]) begin errors++; $display("FAIL alu_op%b: got %h want %h", ops[i], alu_result_o, exps[i]); end
      checks++; if (zero_o !== 1'b0) begin errors++; $display("FAIL alu_zero_op%b: got %b want 0", ops[i], zero_o); end
    end
    reg_data_1_i = 32'h1234_5678; reg_data_2_i = 32'h1234_5678; alu_control_i = 3'b110; #1;
    checks++; if (alu_result_o !== 32'h0) begin errors++; $display("FAIL alu_sub_eq: got %h want 0", alu_result_o); end
    checks++; if (zero_o !== 1'b1) begin errors++; $display("FAIL alu_zero_eq: got %b want 1", zero_o); end
  endtask

  task automatic test_store_load();
    @(negedge clk_i);
    instruction_i = INSTR_SW; reg_data_1_i = 32'h10; alu_src_i = 1'b1;
    alu_control_i = 3'b010; reg_data_2_i = 32'hDEAD_BEEF; mem_write_i = 1'b1; #1;
    checks++; if (alu_result_o !== 32'h14) begin errors++; $display("FAIL st_addr: got %h want 00000014", alu_result_o); end
    checks++; if (mem_data_o !== 32'h0) begin errors++; $display("FAIL st_before_edge: got %h want 0", mem_data_o); end
    @(posedge clk_i); #1;
    mem_write_i = 1'b0; reg_data_2_i = 32'h0;
    checks++; if (mem_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL st_after_edge: got %h want deadbeef", mem_data_o); end
    instruction_i = INSTR_LW; #1;
    checks++; if (mem_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ld_data: got %h want deadbeef", mem_data_o); end
    reg_data_1_i = 32'h10 + 32'(4 * MEM_WORDS); #1;
    checks++; if (mem_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ld_wrap: got %h want deadbeef", mem_data_o); end
    reg_data_1_i = 32'h13; #1;  // 0x17: low address bits ignored
    checks++; if (mem_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ld_unaligned: got %h want deadbeef", mem_data_o); end
    reg_data_1_i = 32'h0C; #1;  // neighbouring word 0x10 untouched
    checks++; if (mem_data_o !== 32'h0) begin errors++; $display("FAIL ld_neighbour: got %h want 0", mem_data_o); end
  endtask

  task automatic test_read_during_write();
    @(negedge clk_i);
    instruction_i = 32'h0; alu_src_i = 1'b0; alu_control_i = 3'b010;
    reg_data_1_i = 32'h20; reg_data_2_i = 32'h0;  // address 0x20 via rs2 = 0 ... store data below
    mem_write_i = 1'b1;
    // Operand B is reg_data_2_i, so use A = 0x20 - data is irrelevant to address only if B = 0;
    // instead route through the immediate path to keep the address fixed.
    alu_src_i = 1'b1; reg_data_2_i = 32'hAAAA_0000; #1;
    @(posedge clk_i); #1;
    checks++; if (mem_data_o !== 32'hAAAA_0000) begin errors++; $display("FAIL rdw_first: got %h want aaaa0000", mem_data_o); end
    @(negedge clk_i); reg_data_2_i = 32'h5555_FFFF; #1;
    checks++; if (mem_data_o !== 32'hAAAA_0000) begin errors++; $display("FAIL rdw_old: got %h want aaaa0000", mem_data_o); end
    @(posedge clk_i); #1;
    checks++; if (mem_data_o !== 32'h5555_FFFF) begin errors++; $display("FAIL rdw_new: got %h want 5555ffff", mem_data_o); end
    @(negedge clk_i); mem_write_i = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk_i);
    instruction_i = INSTR_LW; alu_src_i = 1'b1; alu_control_i = 3'b010;
    reg_data_1_i = 32'h10; mem_write_i = 1'b0; #2;
    checks++; if (mem_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ar_pre: got %h want deadbeef", mem_data_o); end
    reset_i = 1'b1; #1;
    checks++; if (mem_data_o !== 32'h0) begin errors++; $display("FAIL ar_clear: got %h want 0", mem_data_o); end
    checks++; if (alu_result_o !== 32'h14) begin errors++; $display("FAIL ar_alu: got %h want 00000014", alu_result_o); end
    mem_write_i = 1'b1; reg_data_2_i = 32'h1234_5678;
    @(posedge clk_i); #1;
    checks++; if (mem_data_o !== 32'h0) begin errors++; $display("FAIL ar_write_held: got %h want 0", mem_data_o); end
    @(negedge clk_i); mem_write_i = 1'b0; reset_i = 1'b0; #1;
    checks++; if (mem_data_o !== 32'h0) begin errors++; $display("FAIL ar_after_release: got %h want 0", mem_data_o); end
    reg_data_1_i = 32'h1C; alu_src_i = 1'b0; reg_data_2_i = 32'h4; #1;  // address 0x20
    checks++; if (mem_data_o !== 32'h0) begin errors++; $display("FAIL ar_other_word: got %h want 0", mem_data_o); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_immediates();
    test_alu();
    test_store_load();
    test_read_during_write();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
